decode_regfile_pipe: RTL
========================

DECODE_REGFILE_PIPE -- requirements
Module: decode_regfile_pipe

Interface
REQ-001 Parameters: W, default 8, datapath width; A, default 2, register-field width (NR = 2**A registers); IW = 5+2*A, derived instruction width (9 at default).
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset; asserted when 0, sampled on the Clk rising edge.
REQ-004 instr  input  IW  instruction; fields: cls=[IW-1:IW-2], sub=[IW-3:IW-5], fa=[2A-1:A], fb=[A-1:0].
REQ-005 instr_valid  input  1, instr_ready  output  1  fetch handshake; accept = valid & ready.
REQ-006 alu_a, alu_b  output  W, alu_op  output  4, alu_result  input  W  external combinational ALU.
REQ-007 mem_req, mem_we  output  1, mem_addr, mem_wdata  output  W, mem_rdata  input  W, mem_ack  input  1  data-memory handshake.
REQ-008 branch_up, branch_down  output  1, pc_target  output  W, ack  output  1  program-counter controls.

Function
REQ-009 Decode on accept: cls 00 sub 000 get: R[fb] <= R[R[fa][A-1:0]]; 001 put: R[R[fa][A-1:0]] <= R[fb]; 010 lw: R[fa] <= mem[R[fb]]; 011 sw: mem[R[fb]] <= R[fa]; 100/101/110 seq/sne/slt via ALU op 8/9/10, into R[fa]; 111 nop.
REQ-010 cls 01: sub[2]=1 writes zero-extended {sub[1:0],fa,fb} into R[NR-1]; sub[2]=0 writes ~R[fa] into R[fa].
REQ-011 cls 10: alu_op={1'b0,sub}, alu_a=R[fa], alu_b=R[fb], R[fa] <= alu_result; alu_op=0 whenever no ALU instruction is accepted.
REQ-012 cls 11: if R[fa]==R[fb], pc_target <= R[NR-1] and, in the cycle after accept, branch_down (sub[2]=1) or branch_up (sub[2]=0) pulses for exactly one cycle; all-ones instr is HALT, not branch.
REQ-013 Two stages: D (decode/read, accept cycle) and WB register; register-file write commits on the edge ending the cycle after accept.
REQ-014 D-stage reads, including get/put pointer reads, of the register held in WB return the WB value (forwarding, see REQ-024).
REQ-015 FSM states RUN, MEM_WAIT, HALT; reset enters RUN.
REQ-016 RUN: instr_ready=1 except the cycle a branch pulse is high (one bubble; no instruction accepted then).
REQ-017 Accepted lw/sw: next cycle enter MEM_WAIT, mem_req=1 with mem_addr/mem_wdata/mem_we held stable until the cycle mem_ack=1; instr_ready=0 in MEM_WAIT.
REQ-018 mem_ack is sampled only while mem_req=1; on ack, lw writes mem_rdata to R[fa] at that edge, return to RUN; mem_ack while mem_req=0 is ignored.
REQ-019 Accepted HALT: enter HALT; ack=1 and instr_ready=0 from next cycle until reset; no further writes.
REQ-020 Register index arithmetic truncates to A bits; all data arithmetic is W bits, no carry-out.

Reset
REQ-021 While Reset=0 at an edge: all NR registers, WB stage, pc_target, branch_up/down, mem_req, mem_we, ack cleared to 0; state RUN.
REQ-022 Reset during MEM_WAIT aborts the access: mem_req=0 next cycle, pending lw write discarded, later stray mem_ack ignored.
REQ-023 instr_ready=0 while Reset=0; 1 in the first cycle after release.

Configuration
REQ-024 Macro DECODE_REGFILE_FWD_EN: defined -> REQ-014 forwarding, back-to-back dependent instructions at one per cycle; undefined -> no forwarding, instr_ready=0 for one cycle after every accepted register-writing instruction; architectural results identical.

Verification
REQ-025 Bench covers (W=8, A=2):
- Reset=0 two cycles with garbage instr_valid -> all outputs 0, instr_ready=0; release -> instr_ready=1.
- imm 9'h0EB then cls10 add-type on R3,R3 -> R3=0x2B then 0x56; with FWD_EN no stall, without it one ready-low cycle.
- lw, mem_ack after 3 cycles, rdata 0xA5 -> mem_req high exactly 3 cycles, R[fa]=0xA5, instr_ready low throughout.
- R0=R1=5, R3=0x40, branch sub[2]=1 -> branch_down one-cycle pulse, pc_target=0x40, next cycle instr_ready=0; unequal -> no pulse.
- Reset=0 mid MEM_WAIT, then mem_ack=1 -> no register change, mem_req=0.
- instr 9'h1FF -> ack=1 held, instr_ready=0, later instructions ignored until reset.

Source files
------------

// File: rtl/decode_regfile_pipe.sv
// Two-stage decode / register-file block: D stage decodes and reads, WB stage commits one cycle later.
// Optional operand forwarding from the WB register is enabled by defining DECODE_REGFILE_FWD_EN.
module decode_regfile_pipe #(
    parameter int W  = 8,
    parameter int A  = 2,
    parameter int IW = 5 + 2*A
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [IW-1:0] instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_op,
    input  logic [W-1:0]  alu_result,
    output logic          mem_req,
    output logic          mem_we,
    output logic [W-1:0]  mem_addr,
    output logic [W-1:0]  mem_wdata,
    input  logic [W-1:0]  mem_rdata,
    input  logic          mem_ack,
    output logic          branch_up,
    output logic          branch_down,
    output logic [W-1:0]  pc_target,
    output logic          ack
);

    localparam int NR = 2**A;

`ifdef DECODE_REGFILE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t         state, state_next;
    logic [W-1:0]   regs [NR];
    logic           wb_valid;
    logic [A-1:0]   wb_idx;
    logic [W-1:0]   wb_data;
    logic [A-1:0]   mem_idx;

    logic [1:0]     cls;
    logic [2:0]     sub;
    logic [A-1:0]   fa, fb, ptr;
    logic [W-1:0]   rd_fa, rd_fb, rd_ptr, rd_top;
    logic           accept, is_halt;

    logic           wr_en, mem_start, mem_store, is_alu, br_take, halt_go;
    logic [A-1:0]   wr_idx;
    logic [W-1:0]   wr_data;

    assign cls     = instr[IW-1:IW-2];
    assign sub     = instr[IW-3:IW-5];
    assign fa      = instr[2*A-1:A];
    assign fb      = instr[A-1:0];
    assign is_halt = &instr;

    // A value still sitting in WB is newer than the register file copy.
    assign rd_fa  = (FWD && wb_valid && wb_idx == fa) ? wb_data : regs[fa];
    assign rd_fb  = (FWD && wb_valid && wb_idx == fb) ? wb_data : regs[fb];
    assign ptr    = rd_fa[A-1:0];
    assign rd_ptr = (FWD && wb_valid && wb_idx == ptr) ? wb_data : regs[ptr];
    assign rd_top = (FWD && wb_valid && wb_idx == A'(NR-1)) ? wb_data : regs[NR-1];

    assign instr_ready = Reset && (state == RUN) && !branch_up && !branch_down
                         && (FWD || !wb_valid);
    assign accept      = instr_valid && instr_ready;
    assign ack         = (state == HALT);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = fa;
        wr_data   = rd_fa;
        mem_start = 1'b0;
        mem_store = 1'b0;
        is_alu    = 1'b0;
        alu_op    = 4'd0;
        br_take   = 1'b0;
        halt_go   = 1'b0;
        if (accept) begin
            case (cls)
                2'b00: begin
                    case (sub)
                        3'd0: begin wr_en = 1'b1; wr_idx = fb;  wr_data = rd_ptr; end
                        3'd1: begin wr_en = 1'b1; wr_idx = ptr; wr_data = rd_fb;  end
                        3'd2: mem_start = 1'b1;
                        3'd3: begin mem_start = 1'b1; mem_store = 1'b1; end
                        3'd4, 3'd5, 3'd6: begin
                            is_alu  = 1'b1;
                            alu_op  = {2'b10, sub[1:0]};
                            wr_en   = 1'b1;
                            wr_data = alu_result;
                        end
                        default: ;
                    endcase
                end
                2'b01: begin
                    wr_en = 1'b1;
                    if (sub[2]) begin
                        wr_idx  = '1;
                        wr_data = W'({sub[1:0], fa, fb});
                    end else begin
                        wr_data = ~rd_fa;
                    end
                end
                2'b10: begin
                    is_alu  = 1'b1;
                    alu_op  = {1'b0, sub};
                    wr_en   = 1'b1;
                    wr_data = alu_result;
                end
                default: begin
                    if (is_halt)
                        halt_go = 1'b1;
                    else if (rd_fa == rd_fb)
                        br_take = 1'b1;
                end
            endcase
        end
    end

    assign alu_a = is_alu ? rd_fa : '0;
    assign alu_b = is_alu ? rd_fb : '0;

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (halt_go) state_next = HALT;
                      else if (mem_start) state_next = MEM_WAIT;
            MEM_WAIT: if (mem_ack) state_next = RUN;
            HALT:     state_next = HALT;
            default:  state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= RUN;
            wb_valid    <= 1'b0;
            wb_idx      <= '0;
            wb_data     <= '0;
            pc_target   <= '0;
            branch_up   <= 1'b0;
            branch_down <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_idx     <= '0;
        end else begin
            state       <= state_next;
            wb_valid    <= wr_en;
            wb_idx      <= wr_idx;
            wb_data     <= wr_data;
            branch_up   <= br_take && !sub[2];
            branch_down <= br_take && sub[2];
            if (br_take)
                pc_target <= rd_top;
            if (mem_start) begin
                mem_req   <= 1'b1;
                mem_we    <= mem_store;
                mem_addr  <= rd_fb;
                mem_wdata <= rd_fa;
                mem_idx   <= fa;
            end else if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
        end
    end

    // NOTE: the register file is architecturally visible state, so it is cleared on reset like any flop.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NR; i++)
                regs[i] <= '0;
        end else begin
            if (wb_valid)
                regs[wb_idx] <= wb_data;
            if (mem_req && mem_ack && !mem_we)
                regs[mem_idx] <= mem_rdata;
        end
    end

endmodule
